// File: rtl/blaster_pkg.sv
// blaster_pkg: shared ADC frame sequencer types and default timing constants.
package blaster_pkg;
    localparam int ADC_FRAME_LEN = 16;
    localparam int ADC_LEAD      = 2;
    localparam int ADC_DATA_W    = 12;
    localparam int ADC_PERIOD    = 24;
    localparam int ADC_OVR_W     = 8;
    typedef enum logic [1:0] {IDLE, CONV, QUIET} adc_state_t;
    typedef logic [3:0][ADC_DATA_W-1:0] adc_sample_t;
endpackage

// File: rtl/adc_lane_deser.sv
// adc_lane_deser: MSB-first shift register for one ADC lane with lead-bit error flag.
module adc_lane_deser
    import blaster_pkg::*;
#(
    parameter int DATA_W = ADC_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_lead,
    input  logic              in_data,
    input  logic              sdata,
    output logic [DATA_W-1:0] code,
    output logic              lead_err
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code     <= '0;
            lead_err <= 1'b0;
        end else begin
            if (in_data) code <= {code[DATA_W-2:0], sdata};
            if (start) lead_err <= in_lead & sdata;
            else if (in_lead) lead_err <= lead_err | sdata;
        end
    end
endmodule

// File: rtl/adc_frame_sequencer.sv
// adc_frame_sequencer: periodic ADC chip-select framing, 4-lane capture and valid/ready sample output.
module adc_frame_sequencer
    import blaster_pkg::*;
#(
    parameter int FRAME_LEN = ADC_FRAME_LEN,
    parameter int LEAD      = ADC_LEAD,
    parameter int DATA_W    = ADC_DATA_W,
    parameter int PERIOD    = ADC_PERIOD,
    parameter int OVR_W     = ADC_OVR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    output logic                ad_cs,
    input  logic [1:0]          ad_sdata_a,
    input  logic [1:0]          ad_sdata_b,
    output logic                smp_valid,
    input  logic                smp_ready,
    output logic [4*DATA_W-1:0] smp_data,
    output logic                smp_lead_err,
    output logic [15:0]         smp_seq,
    output logic [OVR_W-1:0]    overrun_cnt,
    output logic                busy
);
    localparam int CW = $clog2(PERIOD);
    localparam logic [CW-1:0] K_LAST = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] Q_LAST = CW'(PERIOD - FRAME_LEN - 1);
    localparam logic [CW-1:0] K_LEAD = CW'(LEAD);
    localparam logic [CW-1:0] K_END  = CW'(LEAD + DATA_W);

    adc_state_t          state, state_nx;
    logic [CW-1:0]       cnt, cnt_nx;
    logic                conv, load;
    logic [3:0]          lanes, lead_errs;
    logic [4*DATA_W-1:0] codes;
    logic [15:0]         frame_seq;

    assign conv  = state == CONV;
    assign load  = conv && cnt == K_LAST;
    assign ad_cs = !conv;
    assign busy  = state != IDLE;
    assign lanes = {ad_sdata_b, ad_sdata_a};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // cnt is the bit index in CONV and the quiet-cycle index in QUIET
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (enable) state_nx = CONV;
            end
            CONV: if (cnt == K_LAST) begin
                state_nx = QUIET;
                cnt_nx   = '0;
            end
            QUIET: if (cnt == Q_LAST) begin
                state_nx = enable ? CONV : IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane
        adc_lane_deser #(.DATA_W(DATA_W)) u_lane (
            .clk     (clk),
            .reset   (reset),
            .start   (conv && cnt == '0),
            .in_lead (conv && cnt < K_LEAD),
            .in_data (conv && cnt >= K_LEAD && cnt < K_END),
            .sdata   (lanes[i]),
            .code    (codes[i*DATA_W +: DATA_W]),
            .lead_err(lead_errs[i])
        );
    end

    // word loads on the edge ending the last CONV cycle; an unconsumed word is overwritten
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            smp_valid    <= 1'b0;
            smp_data     <= '0;
            smp_lead_err <= 1'b0;
            smp_seq      <= '0;
            frame_seq    <= '0;
            overrun_cnt  <= '0;
        end else begin
            smp_valid <= load | (smp_valid & !smp_ready);
            if (load) begin
                smp_data     <= codes;
                smp_lead_err <= |lead_errs;
                smp_seq      <= frame_seq;
                frame_seq    <= frame_seq + 1'b1;
            end
            if (load && smp_valid && !smp_ready && overrun_cnt != '1)
                overrun_cnt <= overrun_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_adc_frame_sequencer.sv
// tb_adc_frame_sequencer: directed checks of framing, capture, handshake, overrun and reset behaviour.
module tb_adc_frame_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        ad_cs;
    logic [1:0]  ad_sdata_a = 2'b11;
    logic [1:0]  ad_sdata_b = 2'b11;
    logic        smp_valid;
    logic        smp_ready = 1'b1;
    logic [47:0] smp_data;
    logic        smp_lead_err;
    logic [15:0] smp_seq;
    logic [7:0]  overrun_cnt;
    logic        busy;

    adc_frame_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .ad_cs       (ad_cs),
        .ad_sdata_a  (ad_sdata_a),
        .ad_sdata_b  (ad_sdata_b),
        .smp_valid   (smp_valid),
        .smp_ready   (smp_ready),
        .smp_data    (smp_data),
        .smp_lead_err(smp_lead_err),
        .smp_seq     (smp_seq),
        .overrun_cnt (overrun_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    localparam logic [47:0] CA = {12'h000, 12'hFFF, 12'h123, 12'hABC};
    localparam logic [47:0] CB = {12'h5A5, 12'h0F0, 12'h801, 12'h7FE};
    localparam logic [47:0] CC = {12'h001, 12'h800, 12'hFFE, 12'h3C3};

    int n_tests = 0;
    int n_fail = 0;
    // lane l carries codes[12l+:12] with lead bits leads[2l+:2]; lane order a0,a1,b0,b1
    logic [47:0] codes = '0;
    logic [7:0]  leads = '0;
    int          kb = 0;
    logic [3:0]  lv;
    logic [15:0] w;

    int          r_low, r_high;
    logic        r_v1, r_v2, r_le, r_busy;
    logic [47:0] r_d;
    logic [15:0] r_s;

    // ADC model: shifts {lead, code, 2 junk ones} out on falling edges while ad_cs is low
    always @(negedge clk) begin
        lv = 4'hF;
        if (ad_cs === 1'b0) begin
            for (int l = 0; l < 4; l++) begin
                w = {leads[2*l +: 2], codes[12*l +: 12], 2'b11};
                if (kb < 16) lv[l] = w[15-kb];
            end
            kb++;
        end else kb = 0;
        ad_sdata_a = lv[1:0];
        ad_sdata_b = lv[3:2];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_conv(input int k);
        int t = 0;
        while (ad_cs !== 1'b0 && t < 100) begin @(negedge clk); t++; end
        if (t == 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_conv: ad_cs stayed %b, expected 0", ad_cs);
        end
        repeat (k) @(negedge clk);
    endtask

    // measures one frame: ends on the first CONV cycle of the next frame (or after 100 idle cycles)
    task automatic run_frame(input logic [47:0] nc, input logic [7:0] nl);
        wait_conv(0);
        r_low = 0;
        while (ad_cs === 1'b0 && r_low < 100) begin r_low++; @(negedge clk); end
        r_v1 = smp_valid;
        r_d  = smp_data;
        r_s  = smp_seq;
        r_le = smp_lead_err;
        @(negedge clk);
        r_v2   = smp_valid;
        r_busy = busy;
        codes  = nc;
        leads  = nl;
        r_high = 1;
        while (ad_cs === 1'b1 && r_high < 100) begin @(negedge clk); r_high++; end
    endtask

    initial begin
        @(negedge clk);
        chk("rst ad_cs", ad_cs, 1);
        chk("rst valid", smp_valid, 0);
        chk("rst data", smp_data, 0);
        chk("rst lead_err", smp_lead_err, 0);
        chk("rst seq", smp_seq, 0);
        chk("rst ovr", overrun_cnt, 0);
        chk("rst busy", busy, 0);

        codes = CA;
        smp_ready = 1'b1;
        reset = 1'b0;
        enable = 1'b1;
        run_frame(CB, 8'h00);
        chk("t1 f0 low", r_low, 16);
        chk("t1 f0 high", r_high, 8);
        chk("t1 f0 v1", r_v1, 1);
        chk("t1 f0 v2", r_v2, 0);
        chk("t1 f0 data", r_d, CA);
        chk("t1 f0 seq", r_s, 0);
        chk("t1 f0 lead", r_le, 0);
        run_frame(CC, 8'h00);
        chk("t1 f1 low", r_low, 16);
        chk("t1 f1 high", r_high, 8);
        chk("t1 f1 data", r_d, CB);
        chk("t1 f1 seq", r_s, 1);
        chk("t1 f1 v2", r_v2, 0);
        run_frame(CC, 8'h00);
        chk("t1 f2 data", r_d, CC);
        chk("t1 f2 seq", r_s, 2);
        chk("t1 ovr", overrun_cnt, 0);

        do_reset();
        codes = CA;
        smp_ready = 1'b0;
        enable = 1'b1;
        run_frame(CB, 8'h00);
        chk("t2 f0 data", r_d, CA);
        chk("t2 f0 ovr", overrun_cnt, 0);
        run_frame(CC, 8'h00);
        chk("t2 f1 data", r_d, CB);
        chk("t2 f1 ovr", overrun_cnt, 1);
        run_frame(CC, 8'h00);
        chk("t2 held data", smp_data, CC);
        chk("t2 held seq", smp_seq, 2);
        chk("t2 held valid", smp_valid, 1);
        chk("t2 ovr", overrun_cnt, 2);
        smp_ready = 1'b1;
        @(negedge clk);
        chk("t2 valid drop", smp_valid, 0);
        chk("t2 ovr after", overrun_cnt, 2);

        do_reset();
        codes = CB;
        enable = 1'b1;
        wait_conv(5);
        chk("t3 busy k5", busy, 1);
        enable = 1'b0;
        run_frame(CB, 8'h00);
        chk("t3 low rest", r_low, 11);
        chk("t3 v1", r_v1, 1);
        chk("t3 data", r_d, CB);
        chk("t3 seq", r_s, 0);
        chk("t3 busy quiet", r_busy, 1);
        chk("t3 cs idle", r_high, 100);
        chk("t3 ad_cs", ad_cs, 1);
        chk("t3 busy idle", busy, 0);

        do_reset();
        codes = CC;
        enable = 1'b1;
        wait_conv(8);
        reset = 1'b1;
        #1;
        chk("t4 cs async", ad_cs, 1);
        chk("t4 busy async", busy, 0);
        repeat (3) @(negedge clk);
        chk("t4 valid", smp_valid, 0);
        reset = 1'b0;
        run_frame(CC, 8'h00);
        chk("t4 low", r_low, 16);
        chk("t4 data", r_d, CC);
        chk("t4 seq", r_s, 0);

        do_reset();
        codes = CA;
        leads = 8'b0000_0100;
        enable = 1'b1;
        run_frame(CA, 8'h00);
        chk("t5 lead err", r_le, 1);
        chk("t5 data", r_d, CA);
        run_frame(CA, 8'h00);
        chk("t5 lead clear", r_le, 0);
        chk("t5 data2", r_d, CA);

        do_reset();
        codes = CB;
        smp_ready = 1'b0;
        enable = 1'b1;
        for (int f = 0; f < 300; f++) begin
            run_frame(CB, 8'h00);
            if (f == 99) chk("t6 ovr 100", overrun_cnt, 99);
        end
        chk("t6 ovr sat", overrun_cnt, 255);
        chk("t6 seq", r_s, 299);
        chk("t6 data", r_d, CB);
        chk("t6 valid", smp_valid, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
